// File: rtl/pipe_wb_regfile.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : pipe_wb_regfile
// Description : Write-back stage and general register file of the 5-stage
//               pipeline. Selects write-back data (memory or ALU), commits it
//               to a 2**AW-entry register file with r0 hard-wired to zero,
//               serves two combinational read ports and counts commits.
//               Optional macro WB_BYPASS_EN: write-through bypass so a read
//               of the register being committed this cycle sees the new value.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_wb_regfile #(
    parameter int DW = 32,
    parameter int AW = 5
) (
    input  logic          clock,
    input  logic          resetn,
    input  logic          wwreg,
    input  logic          wm2reg,
    input  logic [DW-1:0] wmo,
    input  logic [DW-1:0] walu,
    input  logic [AW-1:0] wrn,
    input  logic [AW-1:0] rna,
    input  logic [AW-1:0] rnb,
    output logic [DW-1:0] qa,
    output logic [DW-1:0] qb,
    output logic [DW-1:0] wdi,
    output logic [31:0]   wr_count
);

    localparam int c_nreg = 2 ** AW;

    logic [DW-1:0] r_mem [c_nreg];
    logic [31:0]   r_wr_count;
    logic          w_commit;
    logic [DW-1:0] w_qa;
    logic [DW-1:0] w_qb;

    // Write-back data select; valid every cycle regardless of wwreg.
    assign wdi = wm2reg ? wmo : walu;

    // A commit needs the enable and a non-zero destination. With wwreg=0 the
    // AND forces 0 even when wrn carries X, keeping the array and counter safe.
    assign w_commit = wwreg & (|wrn);

    // Register array: synchronous clear has priority over a same-edge commit.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            for (int i = 0; i < c_nreg; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_commit) begin
            r_mem[wrn] <= wdi;
        end
    end

    // Commit counter; wraps naturally at 32 bits.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            r_wr_count <= '0;
        end else if (w_commit) begin
            r_wr_count <= r_wr_count + 32'd1;
        end
    end

    // Read ports: address 0 always yields zero; optional same-cycle bypass.
    always_comb begin
        w_qa = '0;
        w_qb = '0;
        if (rna != '0) begin
`ifdef WB_BYPASS_EN
            if (w_commit && (rna == wrn)) begin
                w_qa = wdi;
            end else begin
                w_qa = r_mem[rna];
            end
`else
            w_qa = r_mem[rna];
`endif
        end
        if (rnb != '0) begin
`ifdef WB_BYPASS_EN
            if (w_commit && (rnb == wrn)) begin
                w_qb = wdi;
            end else begin
                w_qb = r_mem[rnb];
            end
`else
            w_qb = r_mem[rnb];
`endif
        end
    end

    assign qa       = w_qa;
    assign qb       = w_qb;
    assign wr_count = r_wr_count;

endmodule
`default_nettype wire

// File: tb/tb_pipe_wb_regfile.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_pipe_wb_regfile
// Description : Directed self-checking bench for pipe_wb_regfile. Expected
//               values are hand-computed constants; expectations for the
//               same-cycle read follow the WB_BYPASS_EN build option.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_wb_regfile;

    localparam int DW = 32;
    localparam int AW = 5;

    logic          clock;
    logic          resetn;
    logic          wwreg;
    logic          wm2reg;
    logic [DW-1:0] wmo;
    logic [DW-1:0] walu;
    logic [AW-1:0] wrn;
    logic [AW-1:0] rna;
    logic [AW-1:0] rnb;
    logic [DW-1:0] qa;
    logic [DW-1:0] qb;
    logic [DW-1:0] wdi;
    logic [31:0]   wr_count;

    int n_checks;
    int n_fail;

    pipe_wb_regfile #(.DW(DW), .AW(AW)) dut (
        .clock    (clock),
        .resetn   (resetn),
        .wwreg    (wwreg),
        .wm2reg   (wm2reg),
        .wmo      (wmo),
        .walu     (walu),
        .wrn      (wrn),
        .rna      (rna),
        .rnb      (rnb),
        .qa       (qa),
        .qb       (qb),
        .wdi      (wdi),
        .wr_count (wr_count)
    );

    // 10 ns clock.
    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge, then settle 1 ns past it before touching inputs.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    logic [31:0] exp_same;

    initial begin
        n_checks = 0;
        n_fail   = 0;
        resetn   = 1'b0;
        wwreg    = 1'b0;
        wm2reg   = 1'b0;
        wmo      = '0;
        walu     = '0;
        wrn      = '0;
        rna      = '0;
        rnb      = '0;

        // 1. Reset held for two edges, then sweep both read ports.
        step();
        step();
        for (int i = 0; i < 32; i++) begin
            rna = AW'(i);
            rnb = AW'(31 - i);
            #1;
            check_eq($sformatf("reset_qa[%0d]", i), qa, 32'h0);
            check_eq($sformatf("reset_qb[%0d]", 31 - i), qb, 32'h0);
        end
        check_eq("reset_wr_count", wr_count, 32'h0);

        // 2. Write-back select: memory data to r5, then ALU data to r6.
        resetn = 1'b1;
        wwreg  = 1'b1;
        wrn    = 5'd5;
        wm2reg = 1'b1;
        wmo    = 32'hDEAD_BEEF;
        walu   = 32'h0000_1234;
        rna    = 5'd1;
        rnb    = 5'd2;
        #1;
        check_eq("wdi_mem", wdi, 32'hDEAD_BEEF);
        step();
        wm2reg = 1'b0;
        wrn    = 5'd6;
        rna    = 5'd5;
        #1;
        check_eq("wdi_alu", wdi, 32'h0000_1234);
        check_eq("r5_mem", qa, 32'hDEAD_BEEF);
        check_eq("wr_count_1", wr_count, 32'd1);
        step();
        wwreg = 1'b0;
        rnb   = 5'd6;
        #1;
        check_eq("r6_alu", qb, 32'h0000_1234);
        check_eq("r5_kept", qa, 32'hDEAD_BEEF);
        check_eq("wr_count_2", wr_count, 32'd2);

        // 3. r0 protection: three edges writing all-ones to r0.
        wwreg  = 1'b1;
        wrn    = 5'd0;
        wm2reg = 1'b1;
        wmo    = 32'hFFFF_FFFF;
        rna    = 5'd0;
        rnb    = 5'd0;
        #1;
        check_eq("r0_pending_qa", qa, 32'h0);
        step();
        step();
        step();
        wwreg = 1'b0;
        #1;
        check_eq("r0_qa", qa, 32'h0);
        check_eq("r0_qb", qb, 32'h0);
        check_eq("r0_wr_count", wr_count, 32'd2);

        // 4. Same-cycle read of the register being written.
        wwreg  = 1'b1;
        wm2reg = 1'b0;
        walu   = 32'h0000_0001;
        wrn    = 5'd7;
        rna    = 5'd3;
        rnb    = 5'd3;
        step();
        walu = 32'hA5A5_A5A5;
        rna  = 5'd7;
        rnb  = 5'd7;
        #1;
`ifdef WB_BYPASS_EN
        exp_same = 32'hA5A5_A5A5;
`else
        exp_same = 32'h0000_0001;
`endif
        check_eq("same_cycle_qa", qa, exp_same);
        check_eq("same_cycle_qb", qb, exp_same);
        check_eq("wr_count_3", wr_count, 32'd3);
        step();
        wwreg = 1'b0;
        #1;
        check_eq("r7_after_qa", qa, 32'hA5A5_A5A5);
        check_eq("r7_after_qb", qb, 32'hA5A5_A5A5);
        check_eq("wr_count_4", wr_count, 32'd4);

        // Disabled write with garbage on the write-side inputs.
        wrn  = 5'd7;
        wmo  = 32'h1111_1111;
        walu = 32'h2222_2222;
        step();
        #1;
        check_eq("no_wwreg_r7", qa, 32'hA5A5_A5A5);
        check_eq("no_wwreg_count", wr_count, 32'd4);

        // 5. Reset coinciding with a commit: the commit is lost.
        wwreg  = 1'b1;
        wrn    = 5'd9;
        wm2reg = 1'b0;
        walu   = 32'h0000_0055;
        resetn = 1'b0;
        step();
        resetn = 1'b1;
        wwreg  = 1'b0;
        rna    = 5'd9;
        rnb    = 5'd7;
        #1;
        check_eq("rst_r9", qa, 32'h0);
        check_eq("rst_r7", qb, 32'h0);
        check_eq("rst_wr_count", wr_count, 32'h0);

        // 6. Counter wrap from all-ones.
        force dut.r_wr_count = 32'hFFFF_FFFF;
        #1;
        release dut.r_wr_count;
        #1;
        check_eq("wrap_preset", wr_count, 32'hFFFF_FFFF);
        wwreg = 1'b1;
        wrn   = 5'd31;
        walu  = 32'h0000_0077;
        step();
        wwreg = 1'b0;
        rna   = 5'd31;
        #1;
        check_eq("wrap_zero", wr_count, 32'h0);
        check_eq("r31", qa, 32'h0000_0077);
        step();
        check_eq("wrap_idle", wr_count, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Hard time limit so the run always ends.
    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete, expected finish before 100000 ns");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
